// File: rtl/ddram_responder.sv
// Memory-window responder on a DDRAM-style burst port: a 64-bit block RAM behind a
// waitrequest handshake, with fixed read latency and a sticky protocol-error flag.
module ddram_responder #(
    parameter int          ADDR_BITS = 12,
    parameter logic [28:0] BASE      = 29'h0600_0000,
    parameter int          RD_LAT    = 2
) (
    input  logic        DDRAM_CLK,
    input  logic        DDRAM_RESET_N,
    output logic        DDRAM_BUSY,
    input  logic [7:0]  DDRAM_BURSTCNT,
    input  logic [28:0] DDRAM_ADDR,
    input  logic        DDRAM_RD,
    input  logic        DDRAM_WE,
    input  logic [63:0] DDRAM_DIN,
    input  logic [7:0]  DDRAM_BE,
    output logic [63:0] DDRAM_DOUT,
    output logic        DDRAM_DOUT_READY,
    input  logic        busy_inject,
    output logic        proto_err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WBURST = 2'd1;
    localparam logic [1:0] S_RLAT   = 2'd2;
    localparam logic [1:0] S_RBURST = 2'd3;

    localparam logic [ADDR_BITS-1:0] IDX_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [3:0]           LAT_LOAD = 4'(RD_LAT - 1);

    logic [1:0]           state;
    logic                 run_q;

    logic [28:0]          offset;
    logic                 in_win;
    logic [ADDR_BITS-1:0] idx_in;
    logic [7:0]           cnt_in;

    logic                 accept;
    logic                 acc_wr;
    logic                 acc_rd;

    logic [ADDR_BITS-1:0] wr_idx;
    logic [7:0]           wr_rem;
    logic                 wr_hit;

    logic [ADDR_BITS-1:0] rd_idx;
    logic [7:0]           iss_rem;
    logic                 rd_hit;
    logic [3:0]           lat_cnt;
    logic                 rd_issue;
    logic                 pipe_v;

    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_wa;
    logic [63:0]          mem_q;
    logic [63:0]          mem [DEPTH];

    assign DDRAM_BUSY = busy_inject | (state == S_RLAT) | (state == S_RBURST);

    // run_q holds off acceptance for one edge after reset release.
    assign accept = run_q & ~DDRAM_BUSY;
    assign acc_wr = accept & DDRAM_WE;
    assign acc_rd = accept & DDRAM_RD;

    assign offset = DDRAM_ADDR - BASE;
    assign in_win = (offset >> ADDR_BITS) == 29'd0;
    assign idx_in = offset[ADDR_BITS-1:0];
    assign cnt_in = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;

    assign rd_issue = ((state == S_RLAT) && (lat_cnt == 4'd0)) ||
                      ((state == S_RBURST) && (iss_rem != 8'd0));

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        mem_we = 1'b0;
        mem_wa = idx_in;
        if (state == S_IDLE) begin
            mem_we = acc_wr & in_win;
        end else if (state == S_WBURST) begin
            mem_we = acc_wr & wr_hit;
            mem_wa = wr_idx;
        end
    end

    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset so it maps onto block RAM; contents survive DDRAM_RESET_N.
    always_ff @(posedge DDRAM_CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (DDRAM_BE[b]) begin
                    mem[mem_wa][8*b +: 8] <= DDRAM_DIN[8*b +: 8];
                end
            end
        end
        if (rd_issue) begin
            mem_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            state            <= S_IDLE;
            wr_idx           <= '0;
            wr_rem           <= 8'd0;
            wr_hit           <= 1'b0;
            rd_idx           <= '0;
            iss_rem          <= 8'd0;
            rd_hit           <= 1'b0;
            lat_cnt          <= 4'd0;
            pipe_v           <= 1'b0;
            DDRAM_DOUT       <= 64'd0;
            DDRAM_DOUT_READY <= 1'b0;
            proto_err        <= 1'b0;
        end else begin
            // Reads are issued one cycle ahead of the beat because the RAM output is registered.
            pipe_v           <= rd_issue;
            DDRAM_DOUT_READY <= pipe_v;
            if (pipe_v) begin
                DDRAM_DOUT <= rd_hit ? mem_q : 64'd0;
            end
            if (rd_issue) begin
                rd_idx  <= rd_idx + IDX_ONE;
                iss_rem <= iss_rem - 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (acc_wr) begin
                        if (DDRAM_RD || (DDRAM_BURSTCNT == 8'd0)) begin
                            proto_err <= 1'b1;
                        end
                        if (cnt_in > 8'd1) begin
                            state  <= S_WBURST;
                            wr_idx <= idx_in + IDX_ONE;
                            wr_rem <= cnt_in - 8'd1;
                            wr_hit <= in_win;
                        end
                    end else if (acc_rd) begin
                        if (DDRAM_BURSTCNT == 8'd0) begin
                            proto_err <= 1'b1;
                        end
                        state   <= S_RLAT;
                        rd_idx  <= idx_in;
                        rd_hit  <= in_win;
                        iss_rem <= cnt_in;
                        lat_cnt <= LAT_LOAD;
                    end
                end
                S_WBURST: begin
                    if (acc_rd) begin
                        proto_err <= 1'b1;
                    end
                    if (acc_wr) begin
                        wr_idx <= wr_idx + IDX_ONE;
                        wr_rem <= wr_rem - 8'd1;
                        if (wr_rem == 8'd1) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_RLAT: begin
                    if (lat_cnt == 4'd0) begin
                        state <= S_RBURST;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                S_RBURST: begin
                    // Leave only once the final beat is on the bus, so BUSY covers every beat.
                    if ((iss_rem == 8'd0) && !pipe_v) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_responder.sv
// Scoreboard bench for ddram_responder: a driver issues randomized and directed bursts,
// a word-array reference model predicts read beats, and a monitor checks data and timing.
module tb_ddram_responder;

    localparam int          ADDR_BITS = 12;
    localparam int          DEPTH     = 1 << ADDR_BITS;
    localparam logic [28:0] BASE      = 29'h0600_0000;
    localparam int          RD_LAT    = 2;

    logic        DDRAM_CLK        = 1'b0;
    logic        DDRAM_RESET_N    = 1'b1;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT   = 8'd0;
    logic [28:0] DDRAM_ADDR       = 29'd0;
    logic        DDRAM_RD         = 1'b0;
    logic        DDRAM_WE         = 1'b0;
    logic [63:0] DDRAM_DIN        = 64'd0;
    logic [7:0]  DDRAM_BE         = 8'd0;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        busy_inject      = 1'b0;
    logic        proto_err;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } beat_t;

    beat_t       sb_q[$];
    logic [63:0] model [DEPTH];
    logic [63:0] wdata [256];
    logic [7:0]  wbe   [256];

    int   n_checks       = 0;
    int   n_fail         = 0;
    int   cyc            = 0;
    int   beats_seen     = 0;
    int   beats_expected = 0;
    logic exp_err        = 1'b0;
    bit   rand_stall     = 1'b0;

    ddram_responder #(
        .ADDR_BITS(ADDR_BITS),
        .BASE     (BASE),
        .RD_LAT   (RD_LAT)
    ) dut (
        .DDRAM_CLK       (DDRAM_CLK),
        .DDRAM_RESET_N   (DDRAM_RESET_N),
        .DDRAM_BUSY      (DDRAM_BUSY),
        .DDRAM_BURSTCNT  (DDRAM_BURSTCNT),
        .DDRAM_ADDR      (DDRAM_ADDR),
        .DDRAM_RD        (DDRAM_RD),
        .DDRAM_WE        (DDRAM_WE),
        .DDRAM_DIN       (DDRAM_DIN),
        .DDRAM_BE        (DDRAM_BE),
        .DDRAM_DOUT      (DDRAM_DOUT),
        .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .busy_inject     (busy_inject),
        .proto_err       (proto_err)
    );

    always #5 DDRAM_CLK = ~DDRAM_CLK;
    always @(posedge DDRAM_CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int win_off(input logic [28:0] addr);
        return int'(addr) - int'(BASE);
    endfunction

    function automatic bit in_window(input logic [28:0] addr);
        int off;
        off = win_off(addr);
        return (off >= 0) && (off < DEPTH);
    endfunction

    function automatic logic [28:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return BASE - 29'($urandom_range(64, 1000));
            1:       return BASE + 29'(DEPTH) + 29'($urandom_range(0, 64));
            2:       return 29'($urandom);
            default: return BASE + 29'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    // Burst beats walk word indices modulo the window depth from the first beat's offset.
    function automatic void model_write(input logic [28:0] addr, input int k,
                                        input logic [63:0] d, input logic [7:0] be);
        int idx;
        if (in_window(addr)) begin
            idx = (win_off(addr) + k) % DEPTH;
            for (int b = 0; b < 8; b++) begin
                if (be[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    function automatic void push_read(input logic [28:0] addr, input logic [7:0] cnt, input int acc);
        int    n;
        beat_t e;
        n = (cnt == 8'd0) ? 1 : int'(cnt);
        for (int k = 0; k < n; k++) begin
            e.data = in_window(addr) ? model[(win_off(addr) + k) % DEPTH] : 64'd0;
            e.cyc  = acc + RD_LAT + 1 + k;
            sb_q.push_back(e);
            beats_expected++;
        end
    endfunction

    task automatic drive_beat(input logic rd, input logic we, input logic [28:0] addr,
                              input logic [7:0] cnt, input logic [63:0] din,
                              input logic [7:0] be, output int acc_cyc);
        int waited;
        waited = 0;
        @(negedge DDRAM_CLK);
        DDRAM_RD = rd; DDRAM_WE = we; DDRAM_ADDR = addr;
        DDRAM_BURSTCNT = cnt; DDRAM_DIN = din; DDRAM_BE = be;
        busy_inject = rand_stall && ($urandom_range(0, 3) == 0);
        #1;
        while (DDRAM_BUSY && waited < 300) begin
            @(negedge DDRAM_CLK);
            waited++;
            busy_inject = rand_stall && ($urandom_range(0, 3) == 0);
            #1;
        end
        if (waited >= 300) check("accept_timeout", 64'(waited), 64'd0);
        acc_cyc = cyc + 1;
        @(posedge DDRAM_CLK);
        #1;
        DDRAM_RD = 1'b0; DDRAM_WE = 1'b0; busy_inject = 1'b0;
    endtask

    // Later beats carry random ADDR/BURSTCNT: only the first beat's values may matter.
    task automatic do_write(input logic [28:0] addr, input logic [7:0] cnt, input int rd_beat);
        int n, acc;
        n = (cnt == 8'd0) ? 1 : int'(cnt);
        if (cnt == 8'd0) exp_err = 1'b1;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 2)) @(posedge DDRAM_CLK);
            drive_beat(k == rd_beat, 1'b1, (k == 0) ? addr : 29'($urandom),
                       (k == 0) ? cnt : 8'($urandom), wdata[k], wbe[k], acc);
            if (k == rd_beat) exp_err = 1'b1;
            model_write(addr, k, wdata[k], wbe[k]);
        end
    endtask

    task automatic do_read(input logic [28:0] addr, input logic [7:0] cnt);
        int acc;
        if (cnt == 8'd0) exp_err = 1'b1;
        drive_beat(1'b1, 1'b0, addr, cnt, {$urandom, $urandom}, 8'($urandom), acc);
        push_read(addr, cnt, acc);
    endtask

    task automatic fill_random(input int n, input bit full_be);
        for (int k = 0; k < n; k++) begin
            wdata[k] = {$urandom, $urandom};
            wbe[k]   = full_be ? 8'hFF : 8'($urandom);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 3000) begin
            @(negedge DDRAM_CLK);
            w++;
        end
        if (w >= 3000) check("drain_timeout", 64'(sb_q.size()), 64'd0);
        repeat (3) @(negedge DDRAM_CLK);
    endtask

    task automatic apply_reset(input bit wait_ready);
        DDRAM_RESET_N = 1'b0;
        DDRAM_RD = 1'b0; DDRAM_WE = 1'b0; busy_inject = 1'b0;
        #1;
        check("rst_dout_ready", 64'(DDRAM_DOUT_READY), 64'd0);
        check("rst_busy_inject_low", 64'(DDRAM_BUSY), 64'd0);
        busy_inject = 1'b1;
        #1;
        check("rst_busy_inject_high", 64'(DDRAM_BUSY), 64'd1);
        busy_inject = 1'b0;
        beats_expected -= sb_q.size();
        sb_q.delete();
        exp_err = 1'b0;
        repeat (2) @(negedge DDRAM_CLK);
        check("rst_dout", DDRAM_DOUT, 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);
        DDRAM_RESET_N = 1'b1;
        if (wait_ready) repeat (2) @(negedge DDRAM_CLK);
    endtask

    always @(negedge DDRAM_CLK) begin
        beat_t e;
        if (DDRAM_DOUT_READY) begin
            beats_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_dout_ready", 64'(DDRAM_DOUT_READY), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("dout_data", DDRAM_DOUT, e.data);
                check("dout_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_during_beat", 64'(DDRAM_BUSY), 64'd1);
            end
        end
    end

    initial begin
        int acc, b0, w;
        #2;
        apply_reset(1'b1);

        // Give every word a known value so any later read has a defined expectation.
        for (int blk = 0; blk < DEPTH / 128; blk++) begin
            fill_random(128, 1'b1);
            do_write(BASE + 29'(blk * 128), 8'd128, -1);
        end

        // Byte-enable merge onto a cleared word, read back the very next cycle.
        wdata[0] = 64'd0; wbe[0] = 8'hFF;
        do_write(29'h0600_0010, 8'd1, -1);
        wdata[0] = 64'h1122_3344_5566_7788; wbe[0] = 8'h0C;
        do_write(29'h0600_0010, 8'd1, -1);
        do_read(29'h0600_0010, 8'd1);
        drain();
        check("be_merge_dout_held", DDRAM_DOUT, 64'h0000_0000_5566_0000);
        check("dout_ready_idle", 64'(DDRAM_DOUT_READY), 64'd0);

        // Index wrap at the top of the window, then confirm beats 3-4 landed at 0 and 1.
        fill_random(4, 1'b1);
        do_write(BASE + 29'd4094, 8'd4, -1);
        do_read(BASE + 29'd4094, 8'd4);
        do_read(BASE, 8'd2);
        drain();

        // A zero byte-enable beat still advances the burst.
        fill_random(3, 1'b1);
        wbe[0] = 8'hA5; wbe[1] = 8'h00; wbe[2] = 8'h3C;
        do_write(BASE + 29'd300, 8'd3, -1);
        do_read(BASE + 29'd300, 8'd3);
        drain();

        // Stall for three cycles with RD held; then stall again during the burst.
        @(negedge DDRAM_CLK);
        DDRAM_RD = 1'b1; DDRAM_ADDR = BASE + 29'd1000; DDRAM_BURSTCNT = 8'd4; busy_inject = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("inject_forces_busy", 64'(DDRAM_BUSY), 64'd1);
            @(negedge DDRAM_CLK);
        end
        busy_inject = 1'b0;
        #1;
        check("inject_released", 64'(DDRAM_BUSY), 64'd0);
        acc = cyc + 1;
        @(posedge DDRAM_CLK);
        #1;
        DDRAM_RD = 1'b0;
        push_read(BASE + 29'd1000, 8'd4, acc);
        busy_inject = 1'b1;
        repeat (5) @(negedge DDRAM_CLK);
        busy_inject = 1'b0;
        drain();

        // Out-of-window traffic: writes discarded, reads return zero.
        fill_random(2, 1'b1);
        do_write(29'h0500_0000, 8'd2, -1);
        do_read(BASE, 8'd2);
        do_read(29'h0500_0000, 8'd2);
        drain();

        rand_stall = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [28:0] a;
            logic [7:0]  c;
            a = rand_addr();
            c = 8'($urandom_range(1, 12));
            if ($urandom_range(0, 1) == 1) begin
                fill_random(int'(c), 1'b0);
                do_write(a, c, -1);
            end else begin
                do_read(a, c);
            end
        end
        rand_stall = 1'b0;
        drain();
        check("proto_err_legal_traffic", 64'(proto_err), 64'(exp_err));

        // RD and WE together in IDLE: write kept, read dropped, error sticky.
        fill_random(1, 1'b1);
        do_write(BASE + 29'd200, 8'd1, 0);
        repeat (8) @(negedge DDRAM_CLK);
        check("rd_we_proto_err", 64'(proto_err), 64'(exp_err));
        do_read(BASE + 29'd200, 8'd1);
        drain();
        check("proto_err_sticky", 64'(proto_err), 64'(exp_err));

        // Reset during beat 2 of an out-of-window 4-beat read.
        do_read(29'h0500_0000, 8'd4);
        b0 = beats_seen;
        w = 0;
        while (beats_seen < b0 + 2 && w < 100) begin
            @(negedge DDRAM_CLK);
            #2;
            w++;
        end
        if (w >= 100) check("mid_burst_timeout", 64'(beats_seen - b0), 64'd2);
        apply_reset(1'b0);

        // Command present from release: must be taken on the second edge, memory intact.
        DDRAM_RD = 1'b1; DDRAM_ADDR = BASE + 29'd4094; DDRAM_BURSTCNT = 8'd2;
        @(posedge DDRAM_CLK);
        @(negedge DDRAM_CLK);
        #1;
        check("release_edge1_not_taken", 64'(DDRAM_BUSY), 64'd0);
        acc = cyc + 1;
        @(posedge DDRAM_CLK);
        #1;
        DDRAM_RD = 1'b0;
        check("release_edge2_taken", 64'(DDRAM_BUSY), 64'd1);
        push_read(BASE + 29'd4094, 8'd2, acc);
        drain();

        // Zero burst count acts as a single beat and flags an error.
        do_read(BASE + 29'h10, 8'd0);
        drain();
        check("zero_count_proto_err", 64'(proto_err), 64'(exp_err));

        // RD during a write burst is ignored but flagged.
        @(negedge DDRAM_CLK);
        apply_reset(1'b1);
        fill_random(3, 1'b1);
        do_write(BASE + 29'd400, 8'd3, 1);
        repeat (6) @(negedge DDRAM_CLK);
        check("wburst_rd_proto_err", 64'(proto_err), 64'(exp_err));
        do_read(BASE + 29'd400, 8'd3);
        drain();

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        check("beat_count", 64'(beats_seen), 64'(beats_expected));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddram_responder.md
DDRAM_RESPONDER -- requirements
Module: ddram_responder

Interface
REQ-001 Parameter ADDR_BITS, default 12; memory depth is 2^ADDR_BITS 64-bit words.
REQ-002 Parameter BASE, default 29'h0600_0000; word address of the window start (byte 0x30000000).
REQ-003 Parameter RD_LAT, default 2, legal 1..15; cycles from read acceptance to the first data beat.
REQ-004 DDRAM_CLK  in  1  sole clock; all logic rises on it.
REQ-005 DDRAM_RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-006 DDRAM_BUSY  out  1  waitrequest; a command or write beat is accepted only in a cycle where DDRAM_BUSY=0.
REQ-007 DDRAM_BURSTCNT  in  8  burst length in beats; sampled with the first beat only.
REQ-008 DDRAM_ADDR  in  29  64-bit word address; sampled with the first beat only.
REQ-009 DDRAM_RD  in  1  read command.
REQ-010 DDRAM_WE  in  1  write beat.
REQ-011 DDRAM_DIN  in  64  write data.
REQ-012 DDRAM_BE  in  8  byte enables; bit n qualifies DIN[8n+7:8n].
REQ-013 DDRAM_DOUT  out  64  read data.
REQ-014 DDRAM_DOUT_READY  out  1  DOUT valid strobe, one pulse per beat.
REQ-015 busy_inject  in  1  test stall; forces DDRAM_BUSY=1 while high.
REQ-016 proto_err  out  1  sticky protocol-error flag.

Function
REQ-017 State machine states: IDLE, WBURST, RLAT, RBURST.
REQ-018 DDRAM_BUSY = busy_inject OR state is RLAT OR state is RBURST.
REQ-019 Window hit: 0 <= ADDR-BASE < 2^ADDR_BITS; index = (ADDR-BASE) mod 2^ADDR_BITS.
REQ-020 Latched burst count: BURSTCNT=0 is treated as 1 and sets proto_err.
REQ-021 IDLE, accepted WE: write beat 1 to the latched index; if the count is >1, go to WBURST with remaining=count-1; otherwise stay in IDLE.
REQ-022 IDLE, accepted RD without WE: latch index and count, load the latency counter with RD_LAT-1, and go to RLAT.
REQ-023 IDLE, RD and WE in the same accepted cycle: perform the write, drop the read, set proto_err.
REQ-024 WBURST: each accepted WE writes the next index, with the index incrementing and wrapping mod 2^ADDR_BITS; on the last beat, return to IDLE.
REQ-025 WBURST, accepted RD: ignore it and set proto_err.
REQ-026 WBURST, no WE: stay in WBURST with no timeout.
REQ-027 Write semantics: only bytes with BE=1 are updated.
REQ-028 Write semantics: writes whose window check fails (per beat) are discarded.
REQ-029 Write semantics: a beat with BE=8'h00 writes nothing but still counts as a beat.
REQ-030 RLAT: decrement the latency counter each cycle; at 0, go to RBURST.
REQ-031 RLAT with RD_LAT=1: issue the first beat in the cycle after acceptance.
REQ-032 RBURST: DDRAM_DOUT_READY=1 every cycle, one beat per cycle, consecutive indices with wrap; after the final beat, go to IDLE.
REQ-033 Out-of-window read beats return 64'h0.
REQ-034 Read latency from the acceptance edge to the first DOUT_READY is exactly RD_LAT+1 cycles, then BURSTCNT back-to-back beats.
REQ-035 busy_inject does not pause RLAT/RBURST progress; it only blocks acceptance.
REQ-036 Read-after-write: a read accepted the cycle after the last write beat returns the new data.
REQ-037 DDRAM_DOUT holds its last value when DOUT_READY=0.
REQ-038 Storage is inferred block RAM, single read port and single write port.

Reset
REQ-039 On DDRAM_RESET_N=0: state=IDLE, DOUT_READY=0, DOUT=0, proto_err=0, counters=0, and DDRAM_BUSY=busy_inject.
REQ-040 Reset mid-burst aborts the burst with no further beats; memory contents are not cleared.
REQ-041 Release is synchronised; the first acceptance is allowed on the second clock edge after deassertion.

Verification
REQ-042 Write ADDR=29'h0600_0010, BURSTCNT=1, DIN=64'h1122334455667788, BE=8'h0C; then read 1 -> DOUT=64'h0000_0000_5566_0000, DOUT_READY on cycle RD_LAT+1.
REQ-043 4-beat write at index 4094 (ADDR_BITS=12), then 4-beat read -> indices 4094, 4095, 0, 1 in order, 4 consecutive DOUT_READY pulses, BUSY=1 throughout.
REQ-044 busy_inject high for 3 cycles while RD is held -> read accepted only on the first low cycle; an in-progress burst is unaffected.
REQ-045 RD and WE together in IDLE -> the write lands, no DOUT_READY pulse, proto_err=1 until reset.
REQ-046 Read ADDR=29'h0500_0000 (outside window) -> DOUT=0 beats, memory unchanged; reset during RBURST beat 2 of 4 -> DOUT_READY=0 next cycle, state=IDLE.
